ddr_axi_cmd_arbiter: RTL and testbench
======================================

Name: ddr_axi_cmd_arbiter

Overview:
Round-robin arbiter that lets NUM_REQ DDR test traffic generators share one command port of the DDR controller user interface. Each generator supplies address, burst length, ID and direction. The arbiter issues one burst at a time and waits for the datapath's write or read completion pulse before granting again. It sits between the per-generator test sequencers and the write/read datapath that drives the DDR controller AXI channels.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CTRL_ADDR_WIDTH, 28, command address width
LEN_WIDTH, 4, burst length field width
ID_WIDTH, 4, AXI ID width
TIMEOUT_CYCLES, 4096, max cycles from command handshake to completion pulse (≤ 65535)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ddrc_init_done  in  1  DDR controller calibrated; no grant while low
enable  in  1  permits new grants; in-flight burst always completes
req_valid  in  NUM_REQ  per-requester command request
req_write  in  NUM_REQ  1 = write burst, 0 = read burst
req_addr  in  NUM_REQ*CTRL_ADDR_WIDTH  packed addresses, requester i at [i*W +: W]
req_len  in  NUM_REQ*LEN_WIDTH  packed burst lengths
req_id  in  NUM_REQ*ID_WIDTH  packed AXI IDs
req_ack  out  NUM_REQ  one-cycle pulse: command accepted by controller
req_done  out  NUM_REQ  one-cycle pulse: burst completed
cmd_valid  out  1  command valid to datapath
cmd_ready  in  1  datapath accepts command
cmd_write  out  1  latched direction
cmd_addr  out  CTRL_ADDR_WIDTH  latched address
cmd_len  out  LEN_WIDTH  latched length
cmd_id  out  ID_WIDTH  latched ID
write_done_p  in  1  write burst complete pulse
read_done_p  in  1  read burst complete pulse
grant_idx  out  3  index of current/last granted requester
busy  out  1  state != IDLE
timeout_err  out  1  sticky: completion not received in time
burst_cnt  out  32  completed bursts, wraps at 2^32

Behaviour:
- Reset (rst high at a clk edge): state IDLE. rr_ptr=0. All outputs 0, including cmd_* fields, grant_idx, timeout_err and burst_cnt. Reset mid-burst abandons the burst with no req_ack/req_done.
- States: IDLE, CMD, WAIT_DONE.
- IDLE: if ddrc_init_done & enable & |req_valid, select the first set req_valid bit searching rr_ptr, rr_ptr+1, … with wrap mod NUM_REQ. Latch that requester's fields into cmd_*. Set grant_idx. Set rr_ptr = (g+1) mod NUM_REQ. Go to CMD with cmd_valid=1 on the next cycle (latency 1 from req_valid to cmd_valid).
- CMD: cmd_valid and cmd_* are held stable until cmd_valid & cmd_ready. On that edge: cmd_valid←0, req_ack[g] pulses for the following cycle, timeout counter←0, state→WAIT_DONE. Requester deasserting req_valid after the grant has no effect; the latched command is still issued.
- WAIT_DONE: the completion pulse matching cmd_write (write_done_p if 1, read_done_p if 0) causes, on the next cycle: req_done[g] pulse, burst_cnt+1, state IDLE. A non-matching pulse is ignored. If both pulses arrive in the same cycle, the matching one is honoured. The earliest next cmd_valid is 2 cycles after the done pulse.
- Timeout: the counter increments each WAIT_DONE cycle. When it reaches TIMEOUT_CYCLES-1 without a matching pulse, timeout_err←1 (sticky until rst) and state→IDLE with no req_done. A done pulse arriving in that same cycle wins: normal completion, no error.
- enable or ddrc_init_done low only blocks the IDLE→CMD transition.
- A single requester repeatedly valid is re-granted every burst. Fairness: with all requesters valid, grants cycle 0,1,2,3,0,…
- req_ack and req_done are never asserted for more than one bit or one cycle at a time.

Test Plan:
- Reset/idle: rst high 3 cycles, req_valid=4'b1111 with ddrc_init_done=0 → all outputs 0, busy=0, no cmd_valid for 20 cycles.
- Single write: req 2 valid, write=1, addr=28'h0001280, len=4'hF, id=4'h5; cmd_ready high; write_done_p 10 cycles later → cmd_valid one cycle after req_valid with those fields. req_ack=4'b0100 one cycle after handshake. req_done=4'b0100 one cycle after done. burst_cnt=1.
- Round robin: all four valid, immediate ready and done → grant_idx sequence 0,1,2,3,0,1. burst_cnt=6 after six bursts.
- Backpressure/mismatch: cmd_ready low 7 cycles then high → cmd fields stable throughout. During a read burst, write_done_p is ignored; read_done_p completes it.
- Timeout: TIMEOUT_CYCLES=16, no done pulse → timeout_err=1 after 16 WAIT_DONE cycles, state IDLE, no req_done, burst_cnt unchanged. The next request is still served.
- Reset mid-burst: rst in WAIT_DONE → next cycle cmd_valid=0, busy=0, burst_cnt=0, rr_ptr=0 (next grant goes to requester 0 when all are valid).

Source files
------------

// File: rtl/ddr_axi_cmd_arbiter_if.sv
// rtl/ddr_axi_cmd_arbiter_if.sv - requester, command and status bundle for the DDR command arbiter
interface ddr_axi_cmd_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH       = 4,
    parameter int ID_WIDTH        = 4
);
    logic                           ddrc_init_done;
    logic                           enable;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ*CTRL_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]   req_len;
    logic [NUM_REQ*ID_WIDTH-1:0]    req_id;
    logic [NUM_REQ-1:0]             req_ack;
    logic [NUM_REQ-1:0]             req_done;
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic                           cmd_write;
    logic [CTRL_ADDR_WIDTH-1:0]     cmd_addr;
    logic [LEN_WIDTH-1:0]           cmd_len;
    logic [ID_WIDTH-1:0]            cmd_id;
    logic                           write_done_p;
    logic                           read_done_p;
    logic [2:0]                     grant_idx;
    logic                           busy;
    logic                           timeout_err;
    logic [31:0]                    burst_cnt;

    modport slave (
        input  ddrc_init_done, enable, req_valid, req_write, req_addr, req_len, req_id,
        input  cmd_ready, write_done_p, read_done_p,
        output req_ack, req_done, cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        output grant_idx, busy, timeout_err, burst_cnt
    );

    modport master (
        output ddrc_init_done, enable, req_valid, req_write, req_addr, req_len, req_id,
        output cmd_ready, write_done_p, read_done_p,
        input  req_ack, req_done, cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
        input  grant_idx, busy, timeout_err, burst_cnt
    );
endinterface

// File: rtl/ddr_axi_cmd_arbiter.sv
// rtl/ddr_axi_cmd_arbiter.sv - round-robin arbiter sharing one DDR command port among traffic generators
module ddr_axi_cmd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH       = 4,
    parameter int ID_WIDTH        = 4,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    ddr_axi_cmd_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT_DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [2:0]                 r_rr_ptr;
    logic [2:0]                 r_gidx;
    logic [NUM_REQ-1:0]         r_ack;
    logic [NUM_REQ-1:0]         r_done;
    logic                       r_cmd_valid;
    logic                       r_cmd_write;
    logic [CTRL_ADDR_WIDTH-1:0] r_cmd_addr;
    logic [LEN_WIDTH-1:0]       r_cmd_len;
    logic [ID_WIDTH-1:0]        r_cmd_id;
    logic                       r_timeout_err;
    logic [31:0]                r_burst_cnt;
    logic [15:0]                r_tcnt;

    logic                       w_found;
    logic [2:0]                 w_gidx;
    logic [2:0]                 w_next_ptr;
    logic                       w_sel_write;
    logic [CTRL_ADDR_WIDTH-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]       w_sel_len;
    logic [ID_WIDTH-1:0]        w_sel_id;
    logic                       w_match;
    logic                       w_timeout;
    logic [NUM_REQ-1:0]         w_onehot;
    int                         w_dist;
    int                         w_best;

    // Pick the valid requester closest to rr_ptr going upward with wrap.
    always_comb begin
        w_found     = 1'b0;
        w_gidx      = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_id    = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) w_dist = w_dist + NUM_REQ;
            if (bus.req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                w_gidx      = 3'(i);
                w_sel_write = bus.req_write[i];
                w_sel_addr  = bus.req_addr[i*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
                w_sel_len   = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
                w_sel_id    = bus.req_id[i*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_gidx == 3'(NUM_REQ - 1)) ? 3'd0 : w_gidx + 3'd1;
    assign w_match    = r_cmd_write ? bus.write_done_p : bus.read_done_p;
    assign w_timeout  = (r_tcnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gidx;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (bus.ddrc_init_done && bus.enable && w_found) w_state_next = CMD;
            CMD:       if (bus.cmd_ready) w_state_next = WAIT_DONE;
            WAIT_DONE: if (w_match || w_timeout) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_gidx        <= '0;
            r_ack         <= '0;
            r_done        <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_write   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_len     <= '0;
            r_cmd_id      <= '0;
            r_timeout_err <= 1'b0;
            r_burst_cnt   <= '0;
            r_tcnt        <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: if (w_state_next == CMD) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_write <= w_sel_write;
                    r_cmd_addr  <= w_sel_addr;
                    r_cmd_len   <= w_sel_len;
                    r_cmd_id    <= w_sel_id;
                    r_gidx      <= w_gidx;
                    r_rr_ptr    <= w_next_ptr;
                end
                CMD: if (bus.cmd_ready) begin
                    r_cmd_valid <= 1'b0;
                    r_ack       <= w_onehot;
                    r_tcnt      <= '0;
                end
                WAIT_DONE: begin
                    // A matching pulse in the final timeout cycle still completes normally.
                    if (w_match) begin
                        r_done      <= w_onehot;
                        r_burst_cnt <= r_burst_cnt + 32'd1;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ack     = r_ack;
    assign bus.req_done    = r_done;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_write   = r_cmd_write;
    assign bus.cmd_addr    = r_cmd_addr;
    assign bus.cmd_len     = r_cmd_len;
    assign bus.cmd_id      = r_cmd_id;
    assign bus.grant_idx   = r_gidx;
    assign bus.busy        = (r_state != IDLE);
    assign bus.timeout_err = r_timeout_err;
    assign bus.burst_cnt   = r_burst_cnt;
endmodule

// File: tb/tb_ddr_axi_cmd_arbiter.sv
// tb/tb_ddr_axi_cmd_arbiter.sv - scoreboard bench for the DDR command arbiter
module tb_ddr_axi_cmd_arbiter;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int LW = 4;
    localparam int IW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_axi_cmd_arbiter_if #(.NUM_REQ(N), .CTRL_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

    ddr_axi_cmd_arbiter #(
        .NUM_REQ(N), .CTRL_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        logic [IW-1:0] id;
        logic [2:0]    g;
    } cmd_t;
    typedef struct {
        logic [N-1:0] v;
        logic [31:0]  cnt;
    } done_t;

    cmd_t         exp_cmd[$];
    logic [N-1:0] exp_ack[$];
    done_t        exp_done[$];

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_cyc = -10;
    int          done_p_cyc = -10;
    logic [31:0] exp_burst = 32'd0;
    bit          resp_en = 1'b1;
    int          resp_delay = 0;
    int          resp_mode = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(string nm, string act, string req);
        n_checks++;
        n_err++;
        $display("FAIL %s actual=%s required=%s", nm, act, req);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(int i, logic w, logic [AW-1:0] a, logic [LW-1:0] l, logic [IW-1:0] id);
        bus.req_write[i]        = w;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_len[i*LW +: LW]  = l;
        bus.req_id[i*IW +: IW]   = id;
    endtask

    task automatic expect_burst(int g, logic w, logic [AW-1:0] a, logic [LW-1:0] l,
                                logic [IW-1:0] id, bit completes);
        cmd_t  c;
        done_t d;
        c.w = w; c.a = a; c.l = l; c.id = id; c.g = 3'(g);
        exp_cmd.push_back(c);
        exp_ack.push_back(N'(1) << g);
        if (completes) begin
            exp_burst = exp_burst + 32'd1;
            d.v   = N'(1) << g;
            d.cnt = exp_burst;
            exp_done.push_back(d);
        end
    endtask

    task automatic wait_quiet(string nm, int budget);
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_ack.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail({nm, "_timeout"}, "pending", "drained");
        tick(1);
    endtask

    task automatic wait_cmd(string nm, bit need_ready);
        int n = 0;
        @(negedge clk);
        while (!(bus.cmd_valid === 1'b1 && (!need_ready || bus.cmd_ready === 1'b1)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail({nm, "_wait_cmd"}, "no_cmd_valid", "cmd_valid");
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents a command, ack or done.
    always @(negedge clk) begin
        if (bus.cmd_valid === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                fail("cmd_unexpected", "cmd_valid=1", "cmd_valid=0");
            end else begin
                chk("cmd_write", 64'(bus.cmd_write), 64'(exp_cmd[0].w));
                chk("cmd_addr",  64'(bus.cmd_addr),  64'(exp_cmd[0].a));
                chk("cmd_len",   64'(bus.cmd_len),   64'(exp_cmd[0].l));
                chk("cmd_id",    64'(bus.cmd_id),    64'(exp_cmd[0].id));
                chk("grant_idx", 64'(bus.grant_idx), 64'(exp_cmd[0].g));
                if (bus.cmd_ready === 1'b1) begin
                    hs_cyc = cyc;
                    void'(exp_cmd.pop_front());
                end
            end
        end
        if ((|bus.req_ack) === 1'b1) begin
            if (exp_ack.size() == 0) begin
                fail("ack_unexpected", "req_ack!=0", "req_ack=0");
            end else begin
                chk("req_ack", 64'(bus.req_ack), 64'(exp_ack.pop_front()));
                chk("ack_latency", 64'(cyc), 64'(hs_cyc + 1));
            end
        end
        if ((|bus.req_done) === 1'b1) begin
            if (exp_done.size() == 0) begin
                fail("done_unexpected", "req_done!=0", "req_done=0");
            end else begin
                done_t d;
                d = exp_done.pop_front();
                chk("req_done", 64'(bus.req_done), 64'(d.v));
                chk("burst_cnt", 64'(bus.burst_cnt), 64'(d.cnt));
                chk("done_latency", 64'(cyc), 64'(done_p_cyc + 1));
            end
        end
    end

    // Datapath model: answers each accepted command with a completion pulse.
    initial begin
        logic w;
        bus.write_done_p = 1'b0;
        bus.read_done_p  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1 && !rst && resp_en) begin
                w = bus.cmd_write;
                tick(1);
                if (resp_delay > 0) tick(resp_delay);
                if (resp_mode == 1) begin
                    if (w) bus.read_done_p = 1'b1;
                    else   bus.write_done_p = 1'b1;
                    tick(1);
                    bus.write_done_p = 1'b0;
                    bus.read_done_p  = 1'b0;
                    tick(2);
                end
                if (resp_mode == 2) begin
                    bus.write_done_p = 1'b1;
                    bus.read_done_p  = 1'b1;
                end else if (w) begin
                    bus.write_done_p = 1'b1;
                end else begin
                    bus.read_done_p = 1'b1;
                end
                done_p_cyc = cyc;
                tick(1);
                bus.write_done_p = 1'b0;
                bus.read_done_p  = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ddrc_init_done = 1'b0;
        bus.enable         = 1'b0;
        bus.req_valid      = '1;
        bus.req_write      = '0;
        bus.req_addr       = '0;
        bus.req_len        = '0;
        bus.req_id         = '0;
        bus.cmd_ready      = 1'b0;

        // Reset and idle with calibration not done
        rst = 1'b1;
        tick(3);
        chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        chk("rst_cmd_write", 64'(bus.cmd_write), 64'd0);
        chk("rst_cmd_addr",  64'(bus.cmd_addr),  64'd0);
        chk("rst_cmd_len",   64'(bus.cmd_len),   64'd0);
        chk("rst_cmd_id",    64'(bus.cmd_id),    64'd0);
        chk("rst_grant",     64'(bus.grant_idx), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_tmo",       64'(bus.timeout_err), 64'd0);
        chk("rst_burst_cnt", 64'(bus.burst_cnt), 64'd0);
        chk("rst_ack",       64'(bus.req_ack),   64'd0);
        chk("rst_done",      64'(bus.req_done),  64'd0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("noinit_cmd_valid", 64'(bus.cmd_valid), 64'd0);
            chk("noinit_busy", 64'(bus.busy), 64'd0);
        end

        // Single write burst from requester 2
        tick(1);
        bus.req_valid      = '0;
        bus.ddrc_init_done = 1'b1;
        bus.enable         = 1'b1;
        bus.cmd_ready      = 1'b1;
        tick(1);
        set_req(2, 1'b1, 28'h0001280, 4'hF, 4'h5);
        resp_delay = 10;
        resp_mode  = 0;
        expect_burst(2, 1'b1, 28'h0001280, 4'hF, 4'h5, 1'b1);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("lat_cmd_valid_c0", 64'(bus.cmd_valid), 64'd0);
        @(negedge clk);
        chk("lat_cmd_valid_c1", 64'(bus.cmd_valid), 64'd1);
        tick(1);
        bus.req_valid = '0;
        wait_quiet("single_write", 100);
        chk("single_burst_cnt", 64'(bus.burst_cnt), 64'd1);
        chk("single_busy", 64'(bus.busy), 64'd0);

        // enable low blocks grants; withdrawing req_valid after grant still issues the command
        bus.enable    = 1'b0;
        bus.cmd_ready = 1'b0;
        set_req(3, 1'b0, 28'h0ABCDE0, 4'h3, 4'hA);
        bus.req_valid = 4'b1000;
        tick(5);
        chk("enable_low_busy", 64'(bus.busy), 64'd0);
        resp_delay = 0;
        expect_burst(3, 1'b0, 28'h0ABCDE0, 4'h3, 4'hA, 1'b1);
        bus.enable = 1'b1;
        wait_cmd("enable", 1'b0);
        bus.req_valid = '0;
        tick(2);
        bus.cmd_ready = 1'b1;
        wait_quiet("enable", 100);

        // Round robin with all requesters valid, after a fresh reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_burst = 32'd0;
        set_req(0, 1'b1, 28'h0000100, 4'h1, 4'h1);
        set_req(1, 1'b0, 28'h0000200, 4'h2, 4'h2);
        set_req(2, 1'b1, 28'h0000300, 4'h3, 4'h3);
        set_req(3, 1'b0, 28'h0000400, 4'h4, 4'h4);
        expect_burst(0, 1'b1, 28'h0000100, 4'h1, 4'h1, 1'b1);
        expect_burst(1, 1'b0, 28'h0000200, 4'h2, 4'h2, 1'b1);
        expect_burst(2, 1'b1, 28'h0000300, 4'h3, 4'h3, 1'b1);
        expect_burst(3, 1'b0, 28'h0000400, 4'h4, 4'h4, 1'b1);
        expect_burst(0, 1'b1, 28'h0000100, 4'h1, 4'h1, 1'b1);
        expect_burst(1, 1'b0, 28'h0000200, 4'h2, 4'h2, 1'b1);
        bus.req_valid = 4'b1111;
        begin
            int n = 0;
            while (exp_cmd.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) fail("rr_grants", "stalled", "six_grants");
        end
        tick(1);
        bus.req_valid = '0;
        wait_quiet("round_robin", 100);
        chk("rr_burst_cnt", 64'(bus.burst_cnt), 64'd6);
        chk("rr_last_grant", 64'(bus.grant_idx), 64'd1);

        // Backpressure on a read, with a stray write_done_p first
        bus.cmd_ready = 1'b0;
        resp_mode  = 1;
        resp_delay = 2;
        expect_burst(1, 1'b0, 28'h0000200, 4'h2, 4'h2, 1'b1);
        bus.req_valid = 4'b0010;
        wait_cmd("backpressure", 1'b0);
        bus.req_valid = '0;
        repeat (7) begin
            @(negedge clk);
            chk("bp_no_ack", 64'(bus.req_ack), 64'd0);
            chk("bp_cmd_valid", 64'(bus.cmd_valid), 64'd1);
        end
        tick(1);
        bus.cmd_ready = 1'b1;
        wait_quiet("mismatch", 100);

        // Both completion pulses together on a write burst
        resp_mode  = 2;
        resp_delay = 1;
        expect_burst(2, 1'b1, 28'h0000300, 4'h3, 4'h3, 1'b1);
        bus.req_valid = 4'b0100;
        wait_cmd("both_pulses", 1'b0);
        bus.req_valid = '0;
        wait_quiet("both_pulses", 100);

        // Completion arriving in the last timeout cycle wins
        resp_mode  = 0;
        resp_delay = TO - 1;
        expect_burst(3, 1'b0, 28'h0000400, 4'h4, 4'h4, 1'b1);
        bus.req_valid = 4'b1000;
        wait_cmd("edge_done", 1'b0);
        bus.req_valid = '0;
        wait_quiet("edge_done", 100);
        chk("edge_no_tmo", 64'(bus.timeout_err), 64'd0);

        // Timeout with no completion pulse
        resp_en = 1'b0;
        expect_burst(0, 1'b1, 28'h0000100, 4'h1, 4'h1, 1'b0);
        bus.req_valid = 4'b0001;
        wait_cmd("timeout", 1'b1);
        bus.req_valid = '0;
        repeat (TO) @(negedge clk);
        chk("tmo_err_before", 64'(bus.timeout_err), 64'd0);
        chk("tmo_busy_before", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("tmo_err", 64'(bus.timeout_err), 64'd1);
        chk("tmo_idle", 64'(bus.busy), 64'd0);
        chk("tmo_burst_cnt", 64'(bus.burst_cnt), 64'(exp_burst));
        wait_quiet("timeout", 50);
        resp_en    = 1'b1;
        resp_delay = 0;
        expect_burst(2, 1'b1, 28'h0000300, 4'h3, 4'h3, 1'b1);
        bus.req_valid = 4'b0100;
        wait_cmd("after_tmo", 1'b0);
        bus.req_valid = '0;
        wait_quiet("after_tmo", 100);
        chk("tmo_sticky", 64'(bus.timeout_err), 64'd1);

        // Reset during WAIT_DONE abandons the burst and restarts rr_ptr
        resp_en = 1'b0;
        expect_burst(1, 1'b0, 28'h0000200, 4'h2, 4'h2, 1'b0);
        bus.req_valid = 4'b0010;
        wait_cmd("mid_rst", 1'b1);
        bus.req_valid = '0;
        tick(3);
        chk("mid_rst_busy_pre", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_burst = 32'd0;
        exp_cmd.delete();
        exp_ack.delete();
        exp_done.delete();
        chk("mid_rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_burst_cnt", 64'(bus.burst_cnt), 64'd0);
        chk("mid_rst_tmo", 64'(bus.timeout_err), 64'd0);
        resp_en = 1'b1;
        expect_burst(0, 1'b1, 28'h0000100, 4'h1, 4'h1, 1'b1);
        bus.req_valid = 4'b1111;
        begin
            int n = 0;
            while (exp_cmd.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) fail("post_rst_grant", "stalled", "grant");
        end
        tick(1);
        bus.req_valid = '0;
        wait_quiet("post_rst", 100);
        chk("post_rst_burst_cnt", 64'(bus.burst_cnt), 64'd1);

        tick(5);
        chk("end_cmd_q", 64'(exp_cmd.size()), 64'd0);
        chk("end_ack_q", 64'(exp_ack.size()), 64'd0);
        chk("end_done_q", 64'(exp_done.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
